// File: rtl/mux_n_to_1_pipe.sv
// N-to-1 channel multiplexer with a one-deep valid/ready output register.
// The channel index comes from Select (direct) or an internal round-robin pointer.
module mux_n_to_1_pipe #(
    parameter int WIDTH = 32,
    parameter int N     = 7,
    parameter int SEL_W = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N*WIDTH-1:0] I,
    input  logic [SEL_W-1:0]   Select,
    input  logic               rr_mode,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   O,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   O_ch,
    output logic               sel_err
);

    // One extra bit so N == 2**SEL_W still compares correctly.
    localparam logic [SEL_W:0]   N_L    = (SEL_W+1)'(N);
    localparam logic [SEL_W-1:0] LAST_L = SEL_W'(N - 1);

    logic [WIDTH-1:0] o_r;
    logic [SEL_W-1:0] o_ch_r;
    logic             sel_err_r;
    logic             out_valid_r;
    logic [SEL_W-1:0] rr_ptr_r;

    logic             in_ready_s;
    logic             accept_s;
    logic [SEL_W-1:0] idx_s;
    logic             in_range_s;
    logic [WIDTH-1:0] chan_s;
    logic [SEL_W-1:0] rr_next_s;

    assign in_ready_s = !out_valid_r || out_ready;
    assign accept_s   = in_valid && in_ready_s;

    // Index selection, range check and next round-robin pointer.
    always_comb begin
        idx_s      = rr_mode ? rr_ptr_r : Select;
        in_range_s = ({1'b0, idx_s} < N_L);
        rr_next_s  = (rr_ptr_r == LAST_L) ? {SEL_W{1'b0}} : (rr_ptr_r + SEL_W'(1));
    end

    // AND-OR channel mux; an out-of-range index matches no channel and yields zero.
    always_comb begin
        chan_s = {WIDTH{1'b0}};
        for (int k = 0; k < N; k++) begin
            chan_s = chan_s | ({WIDTH{idx_s == SEL_W'(k)}} & I[k*WIDTH +: WIDTH]);
        end
    end

    // Output register, valid flag and round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_r         <= {WIDTH{1'b0}};
            o_ch_r      <= {SEL_W{1'b0}};
            sel_err_r   <= 1'b0;
            out_valid_r <= 1'b0;
            rr_ptr_r    <= {SEL_W{1'b0}};
        end else begin
            if (accept_s) begin
                o_r         <= chan_s;
                o_ch_r      <= idx_s;
                sel_err_r   <= !in_range_s;
                out_valid_r <= 1'b1;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
            if (accept_s && rr_mode) begin
                rr_ptr_r <= rr_next_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign O         = o_r;
    assign O_ch      = o_ch_r;
    assign sel_err   = sel_err_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_mux_n_to_1_pipe.sv
// Scoreboard bench for mux_n_to_1_pipe: stimulus queues expected results,
// a negedge monitor pops and compares each result as it is consumed.
module tb_mux_n_to_1_pipe;

    localparam int WIDTH = 32;
    localparam int N     = 7;
    localparam int SEL_W = 3;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [N*WIDTH-1:0] I;
    logic [SEL_W-1:0]   Select = 3'd0;
    logic               rr_mode = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   O;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [SEL_W-1:0]   O_ch;
    logic               sel_err;

    int total = 0;
    int bad   = 0;
    logic [WIDTH+SEL_W:0] sb_q[$];
    logic model_ov = 1'b0;

    mux_n_to_1_pipe #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) dut (
        .clk(clk), .reset_n(reset_n), .I(I), .Select(Select), .rr_mode(rr_mode),
        .in_valid(in_valid), .in_ready(in_ready), .O(O), .out_valid(out_valid),
        .out_ready(out_ready), .O_ch(O_ch), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: a result is consumed when out_valid && out_ready at the sampling point.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", {32'h0, O}, 64'hDEAD);
            end else begin
                logic [WIDTH+SEL_W:0] e;
                e = sb_q.pop_front();
                check("O",       64'(O),       64'(e[WIDTH+SEL_W:SEL_W+1]));
                check("O_ch",    64'(O_ch),    64'(e[SEL_W:1]));
                check("sel_err", 64'(sel_err), 64'(e[0]));
            end
        end
    end

    // One cycle of stimulus; exp_ch is the hand-computed channel for an accepted request.
    task automatic cyc(input logic v, input logic [2:0] sel, input logic mode,
                       input logic ordy, input int exp_ch);
        logic acc;
        logic [WIDTH-1:0] eo;
        in_valid  = v;
        Select    = sel;
        rr_mode   = mode;
        out_ready = ordy;
        #0;
        check("in_ready", 64'(in_ready), 64'(!model_ov || ordy));
        acc = v && (!model_ov || ordy);
        if (acc) begin
            eo = (exp_ch < N) ? (32'hA0 + 32'(exp_ch)) : 32'h0;
            sb_q.push_back({eo, 3'(exp_ch), (exp_ch >= N) ? 1'b1 : 1'b0});
            model_ov = 1'b1;
        end else if (ordy) begin
            model_ov = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int rr_seq[9] = '{0, 1, 2, 3, 4, 5, 6, 0, 1};

    initial begin
        for (int k = 0; k < N; k++) I[k*WIDTH +: WIDTH] = 32'hA0 + 32'(k);
        #12;
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_O",         64'(O),         64'h0);
        check("rst_O_ch",      64'(O_ch),      64'h0);
        check("rst_sel_err",   64'(sel_err),   64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", 64'(in_ready), 64'h1);

        // Direct select, then out of range, then back in range.
        cyc(1'b1, 3'd4, 1'b0, 1'b1, 4);
        cyc(1'b1, 3'd7, 1'b0, 1'b1, 7);
        cyc(1'b1, 3'd3, 1'b0, 1'b1, 3);
        cyc(1'b0, 3'd0, 1'b0, 1'b1, 0);

        // Round robin for nine accepts, wrapping after channel 6.
        for (int i = 0; i < 9; i++) cyc(1'b1, 3'd5, 1'b1, 1'b1, rr_seq[i]);
        cyc(1'b0, 3'd0, 1'b0, 1'b1, 0);

        // Backpressure: result for channel 2 held while Select changes.
        cyc(1'b1, 3'd2, 1'b0, 1'b1, 2);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 3'(i + 3), 1'b0, 1'b0, 0);
            check("stall_O",     64'(O),         64'hA2);
            check("stall_valid", 64'(out_valid), 64'h1);
        end
        cyc(1'b1, 3'd5, 1'b0, 1'b1, 5);
        cyc(1'b0, 3'd0, 1'b0, 1'b1, 0);

        // Reset with an unconsumed result in the output register.
        cyc(1'b1, 3'd1, 1'b0, 1'b1, 1);
        cyc(1'b0, 3'd0, 1'b0, 1'b0, 0);
        check("pre_rst_valid", 64'(out_valid), 64'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'h0);
        check("async_rst_O",     64'(O),         64'h0);
        sb_q.delete();
        model_ov = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst2", 64'(in_ready), 64'h1);

        // Mode switch: two round-robin, one direct, round-robin resumes at 2.
        cyc(1'b1, 3'd0, 1'b1, 1'b1, 0);
        cyc(1'b1, 3'd0, 1'b1, 1'b1, 1);
        cyc(1'b1, 3'd6, 1'b0, 1'b1, 6);
        cyc(1'b1, 3'd0, 1'b1, 1'b1, 2);
        cyc(1'b0, 3'd0, 1'b0, 1'b1, 0);
        cyc(1'b0, 3'd0, 1'b0, 1'b1, 0);
        check("scoreboard_empty", 64'(sb_q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
